// File: rtl/mips_regfile.sv
// 32 x 32-bit MIPS register file: two async read ports, one sync write port.
// Post-reset init sweep; REGFILE_BYPASS_EN enables same-cycle write-through.
module mips_regfile #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h7FFF_EFFC,
    parameter logic [DATA_WIDTH-1:0] GP_INIT    = 32'h1000_8000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    output logic                  ready,
    output logic                  wr_dropped
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_GP = ADDR_WIDTH'(28);
    localparam logic [ADDR_WIDTH-1:0] IDX_SP = ADDR_WIDTH'(29);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   sidx_q, sidx_d;
    logic                    wr_dropped_q, wr_dropped_d;
    logic [DATA_WIDTH-1:0]   regs_q [DEPTH];

    logic                    we;
    logic [ADDR_WIDTH-1:0]   widx;
    logic [DATA_WIDTH-1:0]   wval;
    logic [DATA_WIDTH-1:0]   init_val;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= CLEAR;
            sidx_q       <= '0;
            wr_dropped_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sidx_q       <= sidx_d;
            wr_dropped_q <= wr_dropped_d;
        end
    end

    // Contents survive reset; only the sweep reinitialises them.
    always_ff @(posedge clock) begin
        if (reset_n && we) begin
            regs_q[widx] <= wval;
        end
    end

    always_comb begin
        init_val = '0;
        if (sidx_q == IDX_GP) init_val = GP_INIT;
        if (sidx_q == IDX_SP) init_val = SP_INIT;
    end

    always_comb begin
        state_d      = state_q;
        sidx_d       = sidx_q;
        wr_dropped_d = 1'b0;
        we           = 1'b0;
        widx         = write_reg;
        wval         = write_data;
        unique case (state_q)
            CLEAR: begin
                we           = 1'b1;
                widx         = sidx_q;
                wval         = init_val;
                sidx_d       = sidx_q + ADDR_WIDTH'(1);
                wr_dropped_d = reg_write;
                if (sidx_q == LAST) state_d = RUN;
            end
            RUN: begin
                we = reg_write && (write_reg != '0);
            end
        endcase
    end

    always_comb begin
        ready      = (state_q == RUN);
        wr_dropped = wr_dropped_q;
        read_data1 = '0;
        read_data2 = '0;
        if (state_q == RUN) begin
            if (read_reg1 != '0) read_data1 = regs_q[read_reg1];
            if (read_reg2 != '0) read_data2 = regs_q[read_reg2];
`ifdef REGFILE_BYPASS_EN
            if (reg_write && write_reg != '0) begin
                if (read_reg1 == write_reg) read_data1 = write_data;
                if (read_reg2 == write_reg) read_data2 = write_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mips_regfile.sv
// Directed self-checking bench for mips_regfile.
// Expectations follow the REGFILE_BYPASS_EN build setting.
module tb_mips_regfile;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [4:0]  read_reg1, read_reg2, write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] read_data1, read_data2;
    logic        ready, wr_dropped;

    int checks = 0;
    int failures = 0;

    mips_regfile dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .ready      (ready),
        .wr_dropped (wr_dropped)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Counts edges until ready, continuing from 'start' edges already seen.
    task automatic wait_ready(input string tag, input int start);
        int n;
        n = start;
        while (!ready && n < 64) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'd32);
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        reg_write  = 1'b1;
        write_reg  = r;
        write_data = d;
        tick();
        reg_write  = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        read_reg1  = 5'd28;
        read_reg2  = 5'd29;
        write_reg  = 5'd0;
        write_data = 32'h0;
        reg_write  = 1'b0;

        repeat (3) tick();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_wr_dropped", 32'(wr_dropped), 32'd0);
        check("rst_rd1", read_data1, 32'h0);

        reset_n = 1'b1;
        wait_ready("sweep1_len", 0);
        read_reg1 = 5'd28;
        read_reg2 = 5'd29;
        #1;
        check("init_gp", read_data1, 32'h1000_8000);
        check("init_sp", read_data2, 32'h7FFF_EFFC);
        read_reg1 = 5'd5;
        #1;
        check("init_r5", read_data1, 32'h0);

        wr(5'd8, 32'hDEAD_BEEF);
        read_reg1 = 5'd8;
        read_reg2 = 5'd8;
        #1;
        check("r8_port1", read_data1, 32'hDEAD_BEEF);
        check("r8_port2", read_data2, 32'hDEAD_BEEF);

        read_reg1 = 5'd0;
        wr(5'd0, 32'h1234_5678);
        check("r0_read", read_data1, 32'h0);
        check("r0_no_drop", 32'(wr_dropped), 32'd0);

        wr(5'd4, 32'h1);
        read_reg1  = 5'd4;
        reg_write  = 1'b1;
        write_reg  = 5'd4;
        write_data = 32'h2;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw_same_cycle", read_data1, 32'h2);
`else
        check("rdw_same_cycle", read_data1, 32'h1);
`endif
        tick();
        reg_write = 1'b0;
        #1;
        check("rdw_next_cycle", read_data1, 32'h2);

        wr(5'd9, 32'hA5A5_A5A5);
        read_reg1 = 5'd9;
        #1;
        check("r9_written", read_data1, 32'hA5A5_A5A5);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midrun_ready", 32'(ready), 32'd0);
        read_reg2 = 5'd29;
        #1;
        check("clear_rd_forced0", read_data2, 32'h0);
        wait_ready("sweep2_len", 0);
        check("r9_cleared", read_data1, 32'h0);

        repeat (9) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midrun2_ready", 32'(ready), 32'd0);
        repeat (9) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midsweep_ready", 32'(ready), 32'd0);

        repeat (9) tick();
        wr(5'd3, 32'hCAFE_F00D);
        check("drop_pulse", 32'(wr_dropped), 32'd1);
        tick();
        check("drop_end", 32'(wr_dropped), 32'd0);
        reg_write = 1'b1;
        tick();
        check("drop_b2b_a", 32'(wr_dropped), 32'd1);
        tick();
        check("drop_b2b_b", 32'(wr_dropped), 32'd1);
        reg_write = 1'b0;
        tick();
        check("drop_b2b_end", 32'(wr_dropped), 32'd0);
        wait_ready("sweep3_len", 14);
        read_reg1 = 5'd3;
        read_reg2 = 5'd0;
        #1;
        check("r3_not_written", read_data1, 32'h0);
        check("r0_port2", read_data2, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
